seletor_minigame: RTL and testbench

Registered, parametrised output selector for the minigame subsystem. It sits between the N minigame cores and the shared display/LED drivers. A start handshake locks the selected game. Outputs are then routed through one register stage, with the selection frozen for the whole game. When the game signals completion, its final result is held until the player confirms or a timeout expires.

---
 rtl/seletor_minigame.sv | 173 +++++++++++++++++
 tb/tb_seletor_minigame.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seletor_minigame.sv
// Registered output selector between N minigame cores and the shared display/LED drivers.
// A start locks one channel; its outputs are routed through one register stage until it finishes or aborts.
module seletor_minigame #(
   parameter int N_JOGOS     = 3,
   parameter int LEDS_W      = 3,
   parameter int ESTADO_W    = 4,
   parameter int JOGADA_W    = 7,
   parameter int PONT_W      = 7,
   parameter int HOLD_CICLOS = 0,
   parameter int SEL_W       = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [SEL_W-1:0]             minigame,
   input  logic                         iniciar,
   input  logic                         abortar,
   input  logic                         confirmar,
   input  logic [ESTADO_W-1:0]          estado_inicial,
   input  logic [N_JOGOS*LEDS_W-1:0]    leds_in,
   input  logic [N_JOGOS*ESTADO_W-1:0]  estado_in,
   input  logic [N_JOGOS*JOGADA_W-1:0]  jogada_in,
   input  logic [N_JOGOS*PONT_W-1:0]    pontuacao_in,
   input  logic [N_JOGOS-1:0]           pronto_in,
   output logic [N_JOGOS-1:0]           habilita,
   output logic [LEDS_W-1:0]            leds_out,
   output logic [ESTADO_W-1:0]          estado_out,
   output logic [JOGADA_W-1:0]          jogada_out,
   output logic [PONT_W-1:0]            pontuacao_out,
   output logic                         pronto_out,
   output logic                         erro_sel,
   output logic [1:0]                   fase
);

   localparam int TW = (HOLD_CICLOS > 0) ? $clog2(HOLD_CICLOS + 1) : 1;
   localparam logic [TW-1:0]    TIMER_FIM = TW'((HOLD_CICLOS > 0) ? HOLD_CICLOS - 1 : 0);
   localparam logic [SEL_W-1:0] N_SEL     = SEL_W'(N_JOGOS);

   typedef enum logic [1:0] {
      OCIOSO   = 2'b00,
      ATIVO    = 2'b01,
      FIM      = 2'b10,
      INVALIDO = 2'b11
   } fase_e;

   fase_e               fase_q, fase_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [LEDS_W-1:0]   leds_q, leds_d;
   logic [ESTADO_W-1:0] estado_q, estado_d;
   logic [JOGADA_W-1:0] jogada_q, jogada_d;
   logic [PONT_W-1:0]   pont_q, pont_d;
   logic [N_JOGOS-1:0]  habilita_q, habilita_d;
   logic                pronto_q, pronto_d;
   logic                erro_q, erro_d;

   logic [LEDS_W-1:0]   ch_leds;
   logic [ESTADO_W-1:0] ch_estado;
   logic [JOGADA_W-1:0] ch_jogada;
   logic [PONT_W-1:0]   ch_pont;
   logic                ch_pronto;

   // Channel mux on the latched selection; unselected channels never reach the outputs.
   always_comb begin
      ch_leds   = '0;
      ch_estado = '0;
      ch_jogada = '0;
      ch_pont   = '0;
      ch_pronto = 1'b0;
      for (int i = 0; i < N_JOGOS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            ch_leds   = leds_in[i*LEDS_W +: LEDS_W];
            ch_estado = estado_in[i*ESTADO_W +: ESTADO_W];
            ch_jogada = jogada_in[i*JOGADA_W +: JOGADA_W];
            ch_pont   = pontuacao_in[i*PONT_W +: PONT_W];
            ch_pronto = pronto_in[i];
         end
      end
   end

   always_comb begin
      fase_d   = fase_q;
      sel_d    = sel_q;
      timer_d  = timer_q;
      leds_d   = leds_q;
      estado_d = estado_q;
      jogada_d = jogada_q;
      pont_d   = pont_q;
      erro_d   = 1'b0;

      case (fase_q)
         OCIOSO: begin
            if (iniciar) begin
               if (minigame < N_SEL) begin
                  sel_d  = minigame;
                  fase_d = ATIVO;
               end else begin
                  erro_d = 1'b1;
               end
            end
         end
         ATIVO: begin
            if (abortar) begin
               fase_d = OCIOSO;
            end else begin
               leds_d   = ch_leds;
               estado_d = ch_estado;
               jogada_d = ch_jogada;
               pont_d   = ch_pont;
               if (ch_pronto) begin
                  fase_d  = FIM;
                  timer_d = '0;
               end
            end
         end
         FIM: begin
            timer_d = timer_q + TW'(1);
            if (confirmar || ((HOLD_CICLOS > 0) && (timer_q == TIMER_FIM))) begin
               fase_d = OCIOSO;
            end
         end
         default: fase_d = OCIOSO;
      endcase

      // Idle display values while in or returning to the menu; a start edge keeps them one more cycle.
      if ((fase_d == OCIOSO) || (fase_q == OCIOSO)) begin
         leds_d   = '0;
         estado_d = estado_inicial;
         jogada_d = '0;
         pont_d   = '0;
      end

      pronto_d = (fase_d == FIM);
      for (int i = 0; i < N_JOGOS; i++) begin
         habilita_d[i] = (fase_d == ATIVO) && (sel_d == SEL_W'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         fase_q     <= OCIOSO;
         sel_q      <= '0;
         timer_q    <= '0;
         leds_q     <= '0;
         estado_q   <= '0;
         jogada_q   <= '0;
         pont_q     <= '0;
         habilita_q <= '0;
         pronto_q   <= 1'b0;
         erro_q     <= 1'b0;
      end else begin
         fase_q     <= fase_d;
         sel_q      <= sel_d;
         timer_q    <= timer_d;
         leds_q     <= leds_d;
         estado_q   <= estado_d;
         jogada_q   <= jogada_d;
         pont_q     <= pont_d;
         habilita_q <= habilita_d;
         pronto_q   <= pronto_d;
         erro_q     <= erro_d;
      end
   end

   assign habilita      = habilita_q;
   assign leds_out      = leds_q;
   assign estado_out    = estado_q;
   assign jogada_out    = jogada_q;
   assign pontuacao_out = pont_q;
   assign pronto_out    = pronto_q;
   assign erro_sel      = erro_q;
   assign fase          = fase_q;

endmodule

// File: tb/tb_seletor_minigame.sv
// Directed bench for seletor_minigame: one instance with a 4-cycle result hold (u_a)
// and one that holds until confirmar (u_b), both driven by the same stimulus.
module tb_seletor_minigame;

   localparam int N  = 3;
   localparam int LW = 3;
   localparam int EW = 4;
   localparam int JW = 7;
   localparam int PW = 7;
   localparam int SW = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic [SW-1:0]   minigame;
   logic            iniciar, abortar, confirmar;
   logic [EW-1:0]   estado_inicial;
   logic [N*LW-1:0] leds_in;
   logic [N*EW-1:0] estado_in;
   logic [N*JW-1:0] jogada_in;
   logic [N*PW-1:0] pontuacao_in;
   logic [N-1:0]    pronto_in;

   logic [N-1:0]  habilita_a, habilita_b;
   logic [LW-1:0] leds_a, leds_b;
   logic [EW-1:0] estado_a, estado_b;
   logic [JW-1:0] jogada_a, jogada_b;
   logic [PW-1:0] pont_a, pont_b;
   logic          pronto_a, pronto_b, erro_a, erro_b;
   logic [1:0]    fase_a, fase_b;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [LW-1:0] exp_q[$];

   seletor_minigame #(.N_JOGOS(N), .LEDS_W(LW), .ESTADO_W(EW), .JOGADA_W(JW), .PONT_W(PW),
                      .HOLD_CICLOS(4), .SEL_W(SW)) u_a (
      .clock(clock), .reset(reset), .minigame(minigame), .iniciar(iniciar), .abortar(abortar),
      .confirmar(confirmar), .estado_inicial(estado_inicial), .leds_in(leds_in),
      .estado_in(estado_in), .jogada_in(jogada_in), .pontuacao_in(pontuacao_in),
      .pronto_in(pronto_in), .habilita(habilita_a), .leds_out(leds_a), .estado_out(estado_a),
      .jogada_out(jogada_a), .pontuacao_out(pont_a), .pronto_out(pronto_a),
      .erro_sel(erro_a), .fase(fase_a));

   seletor_minigame #(.N_JOGOS(N), .LEDS_W(LW), .ESTADO_W(EW), .JOGADA_W(JW), .PONT_W(PW),
                      .HOLD_CICLOS(0), .SEL_W(SW)) u_b (
      .clock(clock), .reset(reset), .minigame(minigame), .iniciar(iniciar), .abortar(abortar),
      .confirmar(confirmar), .estado_inicial(estado_inicial), .leds_in(leds_in),
      .estado_in(estado_in), .jogada_in(jogada_in), .pontuacao_in(pontuacao_in),
      .pronto_in(pronto_in), .habilita(habilita_b), .leds_out(leds_b), .estado_out(estado_b),
      .jogada_out(jogada_b), .pontuacao_out(pont_b), .pronto_out(pronto_b),
      .erro_sel(erro_b), .fase(fase_b));

   // Clock / watchdog
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [LW-1:0] l, input logic [EW-1:0] e,
                         input logic [JW-1:0] j, input logic [PW-1:0] p);
      leds_in[ch*LW +: LW]      = l;
      estado_in[ch*EW +: EW]    = e;
      jogada_in[ch*JW +: JW]    = j;
      pontuacao_in[ch*PW +: PW] = p;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; minigame = '0; iniciar = 0; abortar = 0; confirmar = 0;
      estado_inicial = 4'hA; leds_in = '0; estado_in = '0; jogada_in = '0;
      pontuacao_in = '0; pronto_in = '0;

      // Reset: every output zero, estado_out included
      tick();
      check_eq("rst_fase", fase_a, 2'b00);
      check_eq("rst_estado", estado_a, 4'h0);
      check_eq("rst_habilita", habilita_a, 3'b000);
      check_eq("rst_pronto", pronto_a, 1'b0);
      reset = 1'b1;
      tick();
      check_eq("idle_estado", estado_a, 4'hA);
      check_eq("idle_leds", leds_a, 3'b000);
      check_eq("idle_pont", pont_a, 7'd0);
      check_eq("idle_fase", fase_a, 2'b00);
      check_eq("idle_erro", erro_a, 1'b0);

      // Start channel 1
      set_ch(0, 3'b001, 4'h1, 7'h01, 7'd10);
      set_ch(1, 3'b101, 4'h3, 7'h11, 7'd42);
      set_ch(2, 3'b010, 4'h5, 7'h22, 7'd77);
      minigame = 3'd1; iniciar = 1;
      tick();
      iniciar = 0;
      check_eq("start_fase", fase_a, 2'b01);
      check_eq("start_habilita", habilita_a, 3'b010);
      tick();
      check_eq("route_leds", leds_a, 3'b101);
      check_eq("route_pont", pont_a, 7'd42);
      check_eq("route_estado", estado_a, 4'h3);
      check_eq("route_jogada", jogada_a, 7'h11);

      // Selection stays frozen; unselected pronto ignored
      minigame = 3'd2; iniciar = 1; pronto_in = 3'b100;
      tick();
      iniciar = 0; pronto_in = 3'b000;
      check_eq("frozen_habilita", habilita_a, 3'b010);
      check_eq("frozen_leds", leds_a, 3'b101);
      check_eq("unsel_pronto_fase", fase_a, 2'b01);
      foreach (exp_q[k]) exp_q.delete(k);
      for (int i = 0; i < 3; i++) begin
         logic [LW-1:0] v;
         v = LW'(3 + 2 * i);
         leds_in[1*LW +: LW] = v;
         exp_q.push_back(v);
         tick();
         check_eq("stream_leds", leds_a, exp_q.pop_front());
      end
      leds_in[1*LW +: LW] = 3'b101;

      // Done on channel 1: capture, freeze, timed exit on u_a only
      pronto_in = 3'b010;
      tick();
      pronto_in = 3'b000;
      check_eq("fim_fase", fase_a, 2'b10);
      check_eq("fim_pronto", pronto_a, 1'b1);
      check_eq("fim_pont", pont_a, 7'd42);
      check_eq("fim_habilita", habilita_a, 3'b000);
      set_ch(1, 3'b000, 4'hF, 7'h7F, 7'd99);
      tick();
      check_eq("fim_frozen_pont", pont_a, 7'd42);
      check_eq("fim_frozen_leds", leds_a, 3'b101);
      tick(2);
      check_eq("fim_k3_fase", fase_a, 2'b10);
      tick();
      check_eq("timeout_fase", fase_a, 2'b00);
      check_eq("timeout_estado", estado_a, 4'hA);
      check_eq("timeout_pronto", pronto_a, 1'b0);
      check_eq("timeout_pont", pont_a, 7'd0);
      check_eq("hold0_k4_fase", fase_b, 2'b10);

      // HOLD_CICLOS=0 waits for confirmar
      tick(96);
      check_eq("hold0_k100_fase", fase_b, 2'b10);
      check_eq("hold0_k100_pont", pont_b, 7'd42);
      confirmar = 1;
      tick();
      confirmar = 0;
      check_eq("confirm_fase", fase_b, 2'b00);
      check_eq("confirm_pronto", pronto_b, 1'b0);

      // Invalid selection
      minigame = 3'd3; iniciar = 1;
      tick();
      iniciar = 0;
      check_eq("erro_pulse", erro_a, 1'b1);
      check_eq("erro_fase", fase_a, 2'b00);
      tick();
      check_eq("erro_clear", erro_a, 1'b0);

      // Abort beats pronto
      minigame = 3'd0; iniciar = 1;
      tick();
      iniciar = 0;
      tick();
      check_eq("ch0_leds", leds_a, 3'b001);
      abortar = 1; pronto_in = 3'b001;
      tick();
      abortar = 0; pronto_in = 3'b000;
      check_eq("abort_fase", fase_a, 2'b00);
      check_eq("abort_pronto", pronto_a, 1'b0);
      check_eq("abort_habilita", habilita_a, 3'b000);
      check_eq("abort_estado", estado_a, 4'hA);
      tick();
      check_eq("abort_pronto_after", pronto_b, 1'b0);

      // Reset in ATIVO
      minigame = 3'd2; iniciar = 1;
      tick();
      iniciar = 0;
      tick();
      check_eq("ch2_leds", leds_a, 3'b010);
      reset = 0;
      tick();
      check_eq("rst_ativo_fase", fase_a, 2'b00);
      check_eq("rst_ativo_habilita", habilita_a, 3'b000);
      check_eq("rst_ativo_estado", estado_a, 4'h0);
      check_eq("rst_ativo_leds", leds_a, 3'b000);
      reset = 1;

      // Reset in FIM
      iniciar = 1;
      tick();
      iniciar = 0;
      pronto_in = 3'b100;
      tick();
      pronto_in = 3'b000;
      check_eq("ch2_fim_fase", fase_b, 2'b10);
      reset = 0;
      tick();
      check_eq("rst_fim_fase", fase_b, 2'b00);
      check_eq("rst_fim_pronto", pronto_b, 1'b0);
      check_eq("rst_fim_pont", pont_b, 7'd0);
      reset = 1;
      tick();
      check_eq("rst_fim_idle_estado", estado_b, 4'hA);

      // Restart after reset
      set_ch(0, 3'b011, 4'h6, 7'h33, 7'd5);
      minigame = 3'd0; iniciar = 1;
      tick();
      iniciar = 0;
      tick();
      check_eq("restart_habilita", habilita_a, 3'b001);
      check_eq("restart_leds", leds_a, 3'b011);
      check_eq("restart_pont", pont_a, 7'd5);

      // iniciar held across FIM -> OCIOSO restarts one cycle later
      pronto_in = 3'b001;
      tick();
      pronto_in = 3'b000;
      check_eq("held_fim_fase", fase_b, 2'b10);
      minigame = 3'd1; iniciar = 1; confirmar = 1;
      tick();
      confirmar = 0;
      check_eq("held_exit_fase_b", fase_b, 2'b00);
      check_eq("held_exit_fase_a", fase_a, 2'b00);
      tick();
      iniciar = 0;
      check_eq("held_restart_fase", fase_b, 2'b01);
      check_eq("held_restart_habilita", habilita_b, 3'b010);

      // Final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
